// File: rtl/mips_cpu_control_fsm_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mips_cpu_control_fsm_if                                    |
// | Description : Avalon-style memory bus handshake between the CPU control  |
// |               FSM (master) and the memory/datapath side (slave).         |
// |   waitrequest : slave -> master, access completes when low               |
// |   mem_read    : master -> slave, read request                            |
// |   mem_write   : master -> slave, write request                           |
// |   iord        : master -> slave, 0 = PC address, 1 = ALU result address  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface mips_cpu_control_fsm_if;
  logic waitrequest;
  logic mem_read;
  logic mem_write;
  logic iord;

  modport master (input waitrequest, output mem_read, output mem_write, output iord);
  modport slave  (output waitrequest, input mem_read, input mem_write, input iord);
endinterface
`default_nettype wire

// File: rtl/mips_cpu_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mips_cpu_control_fsm                                       |
// | Description : Multi-cycle MIPS main control unit. Moore FSM sequencing   |
// |               FETCH/DECODE/EXEC/MEM/WB, halting on a fetch from PC 0.    |
// | Ports       : clk, rst_n (sync, active-low)                              |
// |               bus            - memory handshake (master modport)         |
// |               i_instr        - instruction register contents             |
// |               i_pc_zero      - datapath PC equals zero                    |
// |               o_active       - low once halted                           |
// |               o_state        - current state code                        |
// |               o_ir_write, o_pc_write, o_pc_cond, o_reg_write - strobes   |
// |               o_alu_src_a, o_alu_src_b, o_reg_dst, o_mem_to_reg - muxes  |
// |               o_alu_op, o_branchz_func - to alu_control                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mips_cpu_control_fsm (
  input  wire logic              clk,
  input  wire logic              rst_n,
  mips_cpu_control_fsm_if.master bus,
  input  wire logic [31:0]       i_instr,
  input  wire logic              i_pc_zero,
  output logic                   o_active,
  output logic [2:0]             o_state,
  output logic                   o_ir_write,
  output logic                   o_pc_write,
  output logic                   o_pc_cond,
  output logic                   o_reg_write,
  output logic                   o_alu_src_a,
  output logic [1:0]             o_alu_src_b,
  output logic [1:0]             o_reg_dst,
  output logic [1:0]             o_mem_to_reg,
  output logic [3:0]             o_alu_op,
  output logic [4:0]             o_branchz_func
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] c_OP_RTYPE  = 6'b000000;
  localparam logic [5:0] c_OP_REGIMM = 6'b000001;
  localparam logic [5:0] c_OP_J      = 6'b000010;
  localparam logic [5:0] c_OP_JAL    = 6'b000011;
  localparam logic [5:0] c_OP_BEQ    = 6'b000100;
  localparam logic [5:0] c_OP_BNE    = 6'b000101;
  localparam logic [5:0] c_OP_BLEZ   = 6'b000110;
  localparam logic [5:0] c_OP_BGTZ   = 6'b000111;
  localparam logic [5:0] c_OP_ADDIU  = 6'b001001;
  localparam logic [5:0] c_OP_SLTIU  = 6'b001011;
  localparam logic [5:0] c_OP_ANDI   = 6'b001100;
  localparam logic [5:0] c_OP_ORI    = 6'b001101;
  localparam logic [5:0] c_OP_XORI   = 6'b001110;
  localparam logic [5:0] c_OP_LW     = 6'b100011;
  localparam logic [5:0] c_OP_SW     = 6'b101011;

  state_t r_state;
  state_t w_next;
  logic   r_fetch_entry;   // first cycle of the current FETCH visit

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_jr;
  logic       w_jalr;
  logic       w_r_ok;
  logic       w_op_ok;
  logic       w_mem_read, w_mem_write, w_ir_write, w_pc_write, w_pc_cond, w_reg_write;

  assign w_op    = i_instr[31:26];
  assign w_funct = i_instr[5:0];
  assign w_jr    = (w_op == c_OP_RTYPE) && (w_funct == 6'b001000);
  assign w_jalr  = (w_op == c_OP_RTYPE) && (w_funct == 6'b001001);

  // R-type funct validation; malformed encodings (non-zero reserved fields)
  // are treated as unsupported so they fall through as NOPs.
  always_comb begin
    w_r_ok = 1'b0;
    case (w_funct)
      6'b000000, 6'b000010, 6'b000011:
        w_r_ok = (i_instr[25:21] == 5'd0);
      6'b001000:
        w_r_ok = (i_instr[20:6] == 15'd0);
      6'b001001:
        w_r_ok = (i_instr[20:16] == 5'd0) && (i_instr[10:6] == 5'd0);
      6'b000100, 6'b000110, 6'b000111,
      6'b100001, 6'b100011, 6'b100100, 6'b100101,
      6'b100110, 6'b100111, 6'b101010, 6'b101011:
        w_r_ok = (i_instr[10:6] == 5'd0);
      default: w_r_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_op_ok = 1'b0;
    case (w_op)
      c_OP_RTYPE: w_op_ok = w_r_ok;
      c_OP_REGIMM, c_OP_J, c_OP_JAL, c_OP_BEQ, c_OP_BNE, c_OP_BLEZ, c_OP_BGTZ,
      c_OP_ADDIU, c_OP_SLTIU, c_OP_ANDI, c_OP_ORI, c_OP_XORI, c_OP_LW, c_OP_SW:
        w_op_ok = 1'b1;
      default: w_op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_fetch_entry <= 1'b1;
    end else begin
      r_state       <= w_next;
      r_fetch_entry <= (w_next == S_FETCH) && (r_state != S_FETCH);
    end
  end

  always_comb begin
    w_next       = r_state;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_cond    = 1'b0;
    w_reg_write  = 1'b0;
    bus.iord     = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 2'd0;
    o_reg_dst    = 2'd0;
    o_mem_to_reg = 2'd0;
    o_alu_op     = 4'b0000;
    case (r_state)
      S_FETCH: begin
        o_alu_src_b = 2'd1;
        // pc_zero only counts on the entry cycle; stall cycles ignore it
        if (r_fetch_entry && i_pc_zero) begin
          w_next = S_HALT;
        end else begin
          w_mem_read = 1'b1;
          if (!bus.waitrequest) begin
            w_ir_write = 1'b1;
            w_pc_write = 1'b1;
            w_next     = S_DECODE;
          end
        end
      end
      S_DECODE: w_next = w_op_ok ? S_EXEC : S_FETCH;
      S_EXEC: begin
        o_alu_src_a = 1'b1;
        w_next      = S_FETCH;
        case (w_op)
          c_OP_RTYPE: begin
            if (w_jr || w_jalr) begin
              w_pc_write = 1'b1;
              w_next     = w_jalr ? S_WB : S_FETCH;
            end else begin
              o_alu_op = 4'b0010;
              w_next   = S_WB;
            end
          end
          c_OP_ADDIU: begin o_alu_op = 4'b0011; o_alu_src_b = 2'd2; w_next = S_WB; end
          c_OP_ANDI:  begin o_alu_op = 4'b0100; o_alu_src_b = 2'd3; w_next = S_WB; end
          c_OP_ORI:   begin o_alu_op = 4'b0101; o_alu_src_b = 2'd3; w_next = S_WB; end
          c_OP_XORI:  begin o_alu_op = 4'b0110; o_alu_src_b = 2'd3; w_next = S_WB; end
          c_OP_SLTIU: begin o_alu_op = 4'b0111; o_alu_src_b = 2'd2; w_next = S_WB; end
          c_OP_LW, c_OP_SW: begin o_alu_src_b = 2'd2; w_next = S_MEM; end
          c_OP_BEQ:    begin o_alu_op = 4'b0001; w_pc_cond = 1'b1; end
          c_OP_BNE:    begin o_alu_op = 4'b1000; w_pc_cond = 1'b1; end
          c_OP_BGTZ:   begin o_alu_op = 4'b1001; w_pc_cond = 1'b1; end
          c_OP_BLEZ:   begin o_alu_op = 4'b1010; w_pc_cond = 1'b1; end
          c_OP_REGIMM: begin o_alu_op = 4'b1011; w_pc_cond = 1'b1; end
          c_OP_J:      w_pc_write = 1'b1;
          c_OP_JAL:    begin w_pc_write = 1'b1; w_next = S_WB; end
          default:     w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        bus.iord    = 1'b1;
        // request held steady across the stall; never re-issued
        w_mem_read  = (w_op == c_OP_LW);
        w_mem_write = (w_op == c_OP_SW);
        if (!bus.waitrequest) w_next = (w_op == c_OP_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
        case (w_op)
          c_OP_RTYPE: begin o_reg_dst = 2'd1; o_mem_to_reg = w_jalr ? 2'd2 : 2'd0; end
          c_OP_LW:    o_mem_to_reg = 2'd1;
          c_OP_JAL:   begin o_reg_dst = 2'd2; o_mem_to_reg = 2'd2; end
          default:    ;
        endcase
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  // No request or write leaves the unit while reset is held
  assign bus.mem_read  = w_mem_read  & rst_n;
  assign bus.mem_write = w_mem_write & rst_n;
  assign o_ir_write    = w_ir_write  & rst_n;
  assign o_pc_write    = w_pc_write  & rst_n;
  assign o_pc_cond     = w_pc_cond   & rst_n;
  assign o_reg_write   = w_reg_write & rst_n;

  assign o_state        = r_state;
  assign o_active       = (r_state != S_HALT);
  assign o_branchz_func = i_instr[20:16];

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mips_cpu_control_fsm                                    |
// | Description : Self-checking bench for mips_cpu_control_fsm. Expected     |
// |               per-cycle outputs are queued as stimulus is applied and    |
// |               compared mid-cycle by a monitor.                           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mips_cpu_control_fsm;

  // strobe vector order: {mem_read, mem_write, ir_write, pc_write, pc_cond, reg_write}
  localparam logic [5:0] c_MR = 6'b100000;
  localparam logic [5:0] c_MW = 6'b010000;
  localparam logic [5:0] c_IR = 6'b001000;
  localparam logic [5:0] c_PW = 6'b000100;
  localparam logic [5:0] c_PC = 6'b000010;
  localparam logic [5:0] c_RW = 6'b000001;
  // check mask: [0] ALU controls, [1] write-back selects, [2] iord
  localparam logic [2:0] c_K_ALU  = 3'b001;
  localparam logic [2:0] c_K_WB   = 3'b010;
  localparam logic [2:0] c_K_IORD = 3'b100;

  typedef struct {
    logic [2:0] st;
    logic       act;
    logic [5:0] stb;
    logic [2:0] mask;
    logic [3:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       iord;
    logic [4:0] bz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        pc_zero;
  logic        active, ir_write, pc_write, pc_cond, reg_write, alu_src_a;
  logic [2:0]  state;
  logic [1:0]  alu_src_b, reg_dst, mem_to_reg;
  logic [3:0]  alu_op;
  logic [4:0]  bz_func;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  mips_cpu_control_fsm_if bus ();

  mips_cpu_control_fsm dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .i_instr        (instr),
    .i_pc_zero      (pc_zero),
    .o_active       (active),
    .o_state        (state),
    .o_ir_write     (ir_write),
    .o_pc_write     (pc_write),
    .o_pc_cond      (pc_cond),
    .o_reg_write    (reg_write),
    .o_alu_src_a    (alu_src_a),
    .o_alu_src_b    (alu_src_b),
    .o_reg_dst      (reg_dst),
    .o_mem_to_reg   (mem_to_reg),
    .o_alu_op       (alu_op),
    .o_branchz_func (bz_func)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] st, input logic act, input logic [5:0] stb,
                              input logic [2:0] mask, input logic [3:0] aluop, input logic srca,
                              input logic [1:0] srcb, input logic [1:0] rdst,
                              input logic [1:0] m2r, input logic iord);
    exp_t e;
    e.st = st; e.act = act; e.stb = stb; e.mask = mask; e.aluop = aluop;
    e.srca = srca; e.srcb = srcb; e.rdst = rdst; e.m2r = m2r; e.iord = iord;
    e.bz = 5'd0;
    return e;
  endfunction

  function automatic exp_t plain(input logic [2:0] st, input logic [5:0] stb);
    return mk(st, 1'b1, stb, 3'b000, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
  endfunction

  // Apply one cycle of inputs and queue what the DUT must show during it
  task automatic cyc(input logic w, input logic pz, input logic rn, input exp_t e);
    bus.waitrequest = w;
    pc_zero         = pz;
    rst_n           = rn;
    e.bz            = instr[20:16];
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ok();
    cyc(1'b0, 1'b0, 1'b1, mk(3'd0, 1'b1, c_MR | c_IR | c_PW, c_K_ALU | c_K_IORD,
                             4'b0000, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0));
  endtask

  task automatic exec_alu(input logic [3:0] op, input logic [1:0] srcb, input logic [5:0] stb);
    cyc(1'b0, 1'b0, 1'b1, mk(3'd2, 1'b1, stb, c_K_ALU, op, 1'b1, srcb, 2'd0, 2'd0, 1'b0));
  endtask

  task automatic wb(input logic [1:0] rdst, input logic [1:0] m2r);
    cyc(1'b0, 1'b0, 1'b1, mk(3'd4, 1'b1, c_RW, c_K_WB, 4'd0, 1'b0, 2'd0, rdst, m2r, 1'b0));
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state", {29'd0, state}, {29'd0, e.st});
      chk("active", {31'd0, active}, {31'd0, e.act});
      chk("strobes", {26'd0, bus.mem_read, bus.mem_write, ir_write, pc_write, pc_cond, reg_write},
          {26'd0, e.stb});
      chk("branchz_func", {27'd0, bz_func}, {27'd0, e.bz});
      if (e.mask[0]) begin
        chk("alu_op", {28'd0, alu_op}, {28'd0, e.aluop});
        chk("alu_src_a", {31'd0, alu_src_a}, {31'd0, e.srca});
        chk("alu_src_b", {30'd0, alu_src_b}, {30'd0, e.srcb});
      end
      if (e.mask[1]) begin
        chk("reg_dst", {30'd0, reg_dst}, {30'd0, e.rdst});
        chk("mem_to_reg", {30'd0, mem_to_reg}, {30'd0, e.m2r});
      end
      if (e.mask[2]) chk("iord", {31'd0, bus.iord}, {31'd0, e.iord});
    end
  end

  initial begin
    rst_n = 1'b0; pc_zero = 1'b0; bus.waitrequest = 1'b0; instr = 32'h0000_0000;
    @(posedge clk); #1;
    // reset held: FETCH, active, no strobes
    cyc(1'b0, 1'b0, 1'b0, plain(3'd0, 6'd0));

    // addu $3,$1,$2
    instr = 32'h0022_1821;
    fetch_ok();
    cyc(1'b0, 1'b0, 1'b1, plain(3'd1, 6'd0));
    exec_alu(4'b0010, 2'd0, 6'd0);
    wb(2'd1, 2'd0);

    // lw $2,4($1) with two stall cycles in FETCH and in MEM
    instr = 32'h8C22_0004;
    cyc(1'b1, 1'b0, 1'b1, mk(3'd0, 1'b1, c_MR, c_K_IORD, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0));
    cyc(1'b1, 1'b0, 1'b1, mk(3'd0, 1'b1, c_MR, c_K_IORD, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0));
    fetch_ok();
    cyc(1'b0, 1'b0, 1'b1, plain(3'd1, 6'd0));
    exec_alu(4'b0000, 2'd2, 6'd0);
    for (int i = 0; i < 3; i++)
      cyc((i < 2) ? 1'b1 : 1'b0, 1'b0, 1'b1,
          mk(3'd3, 1'b1, c_MR, c_K_IORD, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1));
    wb(2'd0, 2'd1);

    // bgez $1 (REGIMM, rt = 00001)
    instr = 32'h0421_0003;
    fetch_ok();
    cyc(1'b0, 1'b0, 1'b1, plain(3'd1, 6'd0));
    exec_alu(4'b1011, 2'd0, c_PC);

    // xori $2,$1,0xff
    instr = 32'h3822_00FF;
    fetch_ok();
    cyc(1'b0, 1'b0, 1'b1, plain(3'd1, 6'd0));
    exec_alu(4'b0110, 2'd3, 6'd0);
    wb(2'd0, 2'd0);

    // unsupported opcode 0x3F: FETCH, DECODE, back to FETCH
    instr = 32'hFC00_0000;
    fetch_ok();
    cyc(1'b0, 1'b0, 1'b1, plain(3'd1, 6'd0));

    // jal: link into r31
    instr = 32'h0C00_0010;
    fetch_ok();
    cyc(1'b0, 1'b0, 1'b1, plain(3'd1, 6'd0));
    cyc(1'b0, 1'b0, 1'b1, plain(3'd2, c_PW));
    wb(2'd2, 2'd2);

    // jr $0, then halt on the following fetch from PC 0
    instr = 32'h0000_0008;
    fetch_ok();
    cyc(1'b0, 1'b0, 1'b1, plain(3'd1, 6'd0));
    cyc(1'b0, 1'b0, 1'b1, plain(3'd2, c_PW));
    cyc(1'b0, 1'b1, 1'b1, plain(3'd0, 6'd0));
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 1'b1, mk(3'd5, 1'b0, 6'd0, 3'b000, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, mk(3'd5, 1'b0, 6'd0, 3'b000, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0));

    // sw $2,8($1) stalled in MEM, reset asserted on the second stall cycle
    instr = 32'hAC22_0008;
    fetch_ok();
    cyc(1'b0, 1'b0, 1'b1, plain(3'd1, 6'd0));
    exec_alu(4'b0000, 2'd2, 6'd0);
    cyc(1'b1, 1'b0, 1'b1, mk(3'd3, 1'b1, c_MW, c_K_IORD, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1));
    cyc(1'b1, 1'b0, 1'b0, mk(3'd3, 1'b1, 6'd0, c_K_IORD, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1));
    cyc(1'b1, 1'b0, 1'b1, mk(3'd0, 1'b1, c_MR, c_K_IORD, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0));
    fetch_ok();

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) chk("queue_drain", q.size(), 32'd0);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
